alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 8, 16, 32 and 64.
REQ-002 The module SHALL have parameter MULDIV_EN, default 1; when 1, the M-extension ops are implemented, and when 0 they are treated as illegal.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port flush_i, input, 1 bit: synchronous abort of any in-flight operation.
REQ-006 The module SHALL have port in_valid_i, input, 1 bit: the operand set is valid.
REQ-007 The module SHALL have port in_ready_o, output, 1 bit: the block accepts an operand set this cycle.
REQ-008 The module SHALL have port op_i, input, 5 bits: the operation code.
REQ-009 The module SHALL have ports rs1_i and rs2_i, input, XLEN bits each: the operands.
REQ-010 The module SHALL have port out_valid_o, output, 1 bit: the result is valid.
REQ-011 The module SHALL have port out_ready_i, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The module SHALL have port rd_o, output, XLEN bits: the result.
REQ-013 The module SHALL have port zero_o, output, 1 bit: asserted when rd_o equals 0.
REQ-014 The module SHALL have port illegal_o, output, 1 bit: qualified by out_valid_o, asserted when the op was unsupported.

Function
REQ-015 An operand set SHALL be accepted on a cycle with in_valid_i && in_ready_o, sampling op_i, rs1_i and rs2_i on that cycle.
REQ-016 Base ops (op_i[4]=0) SHALL use the following encodings.
- 0000 AND, 0001 OR, 0010 ADD, 0011 EQ, 0100 SLL, 0101 SRL, 0111 SRA.
- 1000 XOR, 1001 NOR, 1010 SUB, 1100 GE, 1101 GEU, 1110 SLT, 1111 SLTU.
- 0110 and 1011 are illegal.
REQ-017 Compare ops SHALL return 1 or 0, zero-extended to XLEN.
REQ-018 Shift amounts SHALL be rs2_i[$clog2(XLEN)-1:0].
REQ-019 ADD and SUB SHALL wrap modulo 2^XLEN.
REQ-020 Muldiv ops (op_i[4]=1) SHALL use the following encodings.
- 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
- 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- 11000 through 11111 are illegal.
REQ-021 Base ops and illegal ops SHALL have latency 1: an accept at cycle N gives out_valid_o at N+1.
REQ-022 Multiplies SHALL use an iterative shift-add, one bit per cycle: an accept at N gives out_valid_o at N+XLEN+1.
- MUL returns the low XLEN bits of the 2*XLEN-bit product.
- MULH, MULHSU and MULHU return the high XLEN bits under signed*signed, signed*unsigned and unsigned*unsigned interpretation respectively.
REQ-023 Divides SHALL use a restoring divider on magnitudes, one quotient bit per cycle, with latency XLEN+1.
- The quotient sign is the XOR of the operand signs.
- The remainder takes the sign of the dividend.
REQ-024 Divide by zero SHALL complete at N+1 with the following results.
- DIV/DIVU return all-ones.
- REM/REMU return rs1.
REQ-025 Signed overflow (rs1 = most-negative, rs2 = -1) SHALL complete at N+1: DIV returns rs1 and REM returns 0.
REQ-026 An illegal op SHALL complete with rd_o = 0, zero_o = 1 and illegal_o = 1.
REQ-027 The FSM SHALL have states IDLE, MUL, DIV and DONE, with these transitions.
- IDLE goes to MUL or DIV on a muldiv accept, and to DONE on a base, illegal or shortcut accept.
- MUL and DIV go to DONE when the iteration counter reaches XLEN-1.
- DONE goes to IDLE on out_ready_i without a new accept.
- DONE follows the IDLE rules on out_ready_i with a new accept.
REQ-028 in_ready_o SHALL equal (state==IDLE || (state==DONE && out_ready_i)) && !flush_i.
- This allows back-to-back base ops at one result per cycle.
REQ-029 While out_valid_o && !out_ready_i, rd_o, zero_o and illegal_o SHALL hold stable.
REQ-030 flush_i SHALL take priority over all other events: the next state is IDLE, out_valid_o is deasserted next cycle, and the in-flight result is discarded.
REQ-031 zero_o SHALL be derived from the registered rd_o.
REQ-032 rd_o SHALL change only at completion.

Reset
REQ-033 On rst_n_i low the block SHALL go to state IDLE asynchronously.
REQ-034 During and after reset, out_valid_o, rd_o and illegal_o SHALL be 0, and zero_o SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL abandon the operation without producing a result.
REQ-036 in_ready_o SHALL be 1 in the first cycle after rst_n_i deasserts.

Structure
REQ-037 The op encodings (5-bit localparams) and the FSM state enumeration SHALL live in the shared package alu_pkg, which other blocks reuse.
REQ-038 The iterative multiply/divide datapath (accumulator, counter, sign fixup) SHALL be the sub-module alu_muldiv_iter.
- It has a start/done interface.
- It is instantiated only when MULDIV_EN=1.
REQ-039 The base combinational ops SHALL remain in alu_mc.

Verification
REQ-040 The bench SHALL cover these directed scenarios, with XLEN=32 unless stated.
- Back-to-back ADD 7+5, SUB 5-7, SRA 0x80000000>>>4 with out_ready held 1 -> rd 12, 0xFFFFFFFE, 0xF8000000 on three consecutive cycles, with in_ready staying 1.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> rd 0 and zero_o=1 at N+33; MULHU on the same operands -> rd 0xFFFFFFFE at N+33.
- DIV -7/2 -> rd 0xFFFFFFFD (-3), and REM -7/2 -> rd 0xFFFFFFFF, both at N+33.
- DIVU 9/0 -> rd 0xFFFFFFFF at N+1; DIV 0x80000000/-1 -> rd 0x80000000 at N+1.
- Backpressure: out_ready held 0 for 5 cycles after completion -> rd stable and in_ready=0; illegal op 01011 -> illegal_o=1 and rd=0.
- flush_i pulsed mid-DIV -> out_valid never rises and in_ready=1 next cycle; rst_n_i pulsed mid-MUL -> all outputs at reset values.
- XLEN=8 run: DIVU 200/7 -> rd 28 at N+9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU family.
// Holds the 5-bit operation encodings and the control FSM state type.
package alu_pkg;

   // Base ops (op[4] = 0)
   localparam logic [4:0] OpAnd    = 5'b00000;
   localparam logic [4:0] OpOr     = 5'b00001;
   localparam logic [4:0] OpAdd    = 5'b00010;
   localparam logic [4:0] OpEq     = 5'b00011;
   localparam logic [4:0] OpSll    = 5'b00100;
   localparam logic [4:0] OpSrl    = 5'b00101;
   localparam logic [4:0] OpSra    = 5'b00111;
   localparam logic [4:0] OpXor    = 5'b01000;
   localparam logic [4:0] OpNor    = 5'b01001;
   localparam logic [4:0] OpSub    = 5'b01010;
   localparam logic [4:0] OpGe     = 5'b01100;
   localparam logic [4:0] OpGeu    = 5'b01101;
   localparam logic [4:0] OpSlt    = 5'b01110;
   localparam logic [4:0] OpSltu   = 5'b01111;

   // Multiply/divide ops (op[4] = 1, op[3] = 0)
   localparam logic [4:0] OpMul    = 5'b10000;
   localparam logic [4:0] OpMulh   = 5'b10001;
   localparam logic [4:0] OpMulhsu = 5'b10010;
   localparam logic [4:0] OpMulhu  = 5'b10011;
   localparam logic [4:0] OpDiv    = 5'b10100;
   localparam logic [4:0] OpDivu   = 5'b10101;
   localparam logic [4:0] OpRem    = 5'b10110;
   localparam logic [4:0] OpRemu   = 5'b10111;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StDone
   } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath, one bit per cycle.
//   start_i  : load operands (op_i = {is_div, sel[1:0]}) and begin XLEN steps
//   flush_i  : abandon the running operation
//   done_o   : high in the cycle of the final step; result_o is valid then
//   result_o : sign-corrected result of the final step
// Multiply: shift-add on magnitudes, acc = {high, multiplier}.
// Divide  : restoring division on magnitudes, acc = {remainder, dividend/quotient}.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CntW = $clog2(XLEN);

   logic              busy_q;
   logic [CntW-1:0]   cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   b_q;
   logic              is_div_q;
   logic [1:0]        sel_q;
   logic              neg_quo_q;
   logic              neg_rem_q;

   logic              sgn_a, sgn_b, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [2*XLEN-1:0] acc_n, prod;
   logic [XLEN-1:0]   quo, rem;

   // Operand signedness at start: MULH both, MULHSU rs1 only, DIV/REM both.
   always_comb begin
      if (op_i[2]) begin
         sgn_a = !op_i[0];
         sgn_b = !op_i[0];
      end else begin
         sgn_a = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
         sgn_b = (op_i[1:0] == 2'b01);
      end
      neg_a = sgn_a && a_i[XLEN-1];
      neg_b = sgn_b && b_i[XLEN-1];
      mag_a = neg_a ? -a_i : a_i;
      mag_b = neg_b ? -b_i : b_i;
   end

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_sh   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_sh - {1'b0, b_q};
      if (is_div_q) begin
         // Negative difference means the divisor does not fit: restore.
         if (div_diff[XLEN]) acc_n = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         else                acc_n = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_n = {mul_sum, acc_q[XLEN-1:1]};
      end

      prod = neg_quo_q ? -acc_n : acc_n;
      quo  = acc_n[XLEN-1:0];
      rem  = acc_n[2*XLEN-1:XLEN];
      if (is_div_q) begin
         if (sel_q[1]) result_o = neg_rem_q ? -rem : rem;
         else          result_o = neg_quo_q ? -quo : quo;
      end else begin
         result_o = (sel_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   assign done_o = busy_q && (cnt_q == CntW'(XLEN - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         is_div_q  <= 1'b0;
         sel_q     <= 2'b00;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (flush_i) begin
         busy_q <= 1'b0;
      end else if (start_i) begin
         busy_q    <= 1'b1;
         cnt_q     <= '0;
         acc_q     <= {{XLEN{1'b0}}, mag_a};
         b_q       <= mag_b;
         is_div_q  <= op_i[2];
         sel_q     <= op_i[1:0];
         neg_quo_q <= neg_a ^ neg_b;
         neg_rem_q <= neg_a;
      end else if (busy_q) begin
         acc_q <= acc_n;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops plus optional iterative M-extension ops.
//   clk_i, rst_n_i           : clock, async active-low reset
//   flush_i                  : synchronous abort of the in-flight op
//   in_valid_i/in_ready_o    : operand handshake (op_i, rs1_i, rs2_i)
//   out_valid_o/out_ready_i  : result handshake (rd_o, zero_o, illegal_o)
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter bit          MULDIV_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] rd_o,
   output logic            zero_o,
   output logic            illegal_o
);

   localparam int unsigned ShW = $clog2(XLEN);

   alu_state_e      state_q, state_d;
   logic [XLEN-1:0] rd_q, rd_d;
   logic            ill_q, ill_d;

   logic [XLEN-1:0] base_res;
   logic            base_ill;
   logic [ShW-1:0]  sh;
   logic            div_by_zero, div_ovf, dispatch;
   logic            md_start, md_done;
   logic [XLEN-1:0] md_result;

   always_comb begin
      base_res = '0;
      base_ill = 1'b0;
      sh       = rs2_i[ShW-1:0];
      case (op_i)
         OpAnd:   base_res = rs1_i & rs2_i;
         OpOr:    base_res = rs1_i | rs2_i;
         OpAdd:   base_res = rs1_i + rs2_i;
         OpEq:    base_res = {{(XLEN-1){1'b0}}, rs1_i == rs2_i};
         OpSll:   base_res = rs1_i << sh;
         OpSrl:   base_res = rs1_i >> sh;
         OpSra:   base_res = $signed(rs1_i) >>> sh;
         OpXor:   base_res = rs1_i ^ rs2_i;
         OpNor:   base_res = ~(rs1_i | rs2_i);
         OpSub:   base_res = rs1_i - rs2_i;
         OpGe:    base_res = {{(XLEN-1){1'b0}}, $signed(rs1_i) >= $signed(rs2_i)};
         OpGeu:   base_res = {{(XLEN-1){1'b0}}, rs1_i >= rs2_i};
         OpSlt:   base_res = {{(XLEN-1){1'b0}}, $signed(rs1_i) < $signed(rs2_i)};
         OpSltu:  base_res = {{(XLEN-1){1'b0}}, rs1_i < rs2_i};
         default: base_ill = 1'b1;
      endcase
   end

   assign div_by_zero = (rs2_i == '0);
   assign div_ovf     = (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

   assign in_ready_o = ((state_q == StIdle) || ((state_q == StDone) && out_ready_i)) && !flush_i;

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      ill_d    = ill_q;
      md_start = 1'b0;
      dispatch = 1'b0;

      case (state_q)
         StIdle: dispatch = in_valid_i;
         StMul, StDiv: begin
            if (md_done) begin
               state_d = StDone;
               rd_d    = md_result;
               ill_d   = 1'b0;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d  = StIdle;
               dispatch = in_valid_i;
            end
         end
         default: state_d = StIdle;
      endcase

      if (dispatch && !flush_i) begin
         if (!op_i[4]) begin
            state_d = StDone;
            rd_d    = base_ill ? '0 : base_res;
            ill_d   = base_ill;
         end else if (!MULDIV_EN || op_i[3]) begin
            state_d = StDone;
            rd_d    = '0;
            ill_d   = 1'b1;
         end else if (!op_i[2]) begin
            state_d  = StMul;
            md_start = 1'b1;
         end else if (div_by_zero) begin
            // Short-circuit: quotient all-ones, remainder is the dividend.
            state_d = StDone;
            rd_d    = op_i[1] ? rs1_i : '1;
            ill_d   = 1'b0;
         end else if (!op_i[0] && div_ovf) begin
            state_d = StDone;
            rd_d    = op_i[1] ? '0 : rs1_i;
            ill_d   = 1'b0;
         end else begin
            state_d  = StDiv;
            md_start = 1'b1;
         end
      end

      if (flush_i) begin
         state_d  = StIdle;
         md_start = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         rd_q    <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         ill_q   <= ill_d;
      end
   end

   if (MULDIV_EN) begin : g_muldiv
      alu_muldiv_iter #(
         .XLEN (XLEN)
      ) u_iter (
         .clk_i    (clk_i),
         .rst_n_i  (rst_n_i),
         .flush_i  (flush_i),
         .start_i  (md_start),
         .op_i     (op_i[2:0]),
         .a_i      (rs1_i),
         .b_i      (rs2_i),
         .done_o   (md_done),
         .result_o (md_result)
      );
   end else begin : g_no_muldiv
      logic unused_md_start;
      assign unused_md_start = md_start;
      assign md_done         = 1'b0;
      assign md_result       = '0;
   end

   assign out_valid_o = (state_q == StDone);
   assign rd_o        = rd_q;
   assign zero_o      = (rd_q == '0);
   assign illegal_o   = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance and an 8-bit instance sharing clock and reset.
module tb_alu_mc;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, ill;
   logic [4:0]  op;
   logic [31:0] rs1, rs2, rd;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, ill8, flush8;
   logic [4:0]  op8;
   logic [7:0]  a8, b8, rd8;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mc #(.XLEN(32), .MULDIV_EN(1'b1)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .rd_o        (rd),
      .zero_o      (zero),
      .illegal_o   (ill)
   );

   alu_mc #(.XLEN(8), .MULDIV_EN(1'b1)) u_dut8 (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .flush_i     (flush8),
      .in_valid_i  (in_valid8),
      .in_ready_o  (in_ready8),
      .op_i        (op8),
      .rs1_i       (a8),
      .rs2_i       (b8),
      .out_valid_o (out_valid8),
      .out_ready_i (out_ready8),
      .rd_o        (rd8),
      .zero_o      (zero8),
      .illegal_o   (ill8)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with out_ready held by the caller, wait for the result, check latency/rd/illegal.
   task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_ill);
      int lat;
      check_eq({tag, ".in_ready"}, in_ready, 1);
      op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check_eq({tag, ".lat"}, lat, exp_lat);
      check_eq({tag, ".rd"}, rd, exp_rd);
      check_eq({tag, ".illegal"}, ill, exp_ill);
   endtask

   initial begin
      int  lat;
      logic seen;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; rs1 = '0; rs2 = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      #1;
      check_eq("rst.out_valid", out_valid, 0);
      check_eq("rst.rd", rd, 0);
      check_eq("rst.illegal", ill, 0);
      check_eq("rst.zero", zero, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst.in_ready_after", in_ready, 1);
      tick();

      // Back-to-back base ops with out_ready held high
      op = OpAdd; rs1 = 32'd7; rs2 = 32'd5; in_valid = 1'b1;
      tick();
      check_eq("b2b.add.valid", out_valid, 1);
      check_eq("b2b.add.rd", rd, 32'd12);
      check_eq("b2b.add.in_ready", in_ready, 1);
      op = OpSub; rs1 = 32'd5; rs2 = 32'd7;
      tick();
      check_eq("b2b.sub.valid", out_valid, 1);
      check_eq("b2b.sub.rd", rd, 32'hFFFF_FFFE);
      check_eq("b2b.sub.in_ready", in_ready, 1);
      op = OpSra; rs1 = 32'h8000_0000; rs2 = 32'd4;
      tick();
      check_eq("b2b.sra.valid", out_valid, 1);
      check_eq("b2b.sra.rd", rd, 32'hF800_0000);
      in_valid = 1'b0;
      tick();
      check_eq("b2b.idle", out_valid, 0);

      // 8-bit instance: DIVU 200/7
      op8 = OpDivu; a8 = 8'd200; b8 = 8'd7; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 100) begin
         tick();
         lat++;
      end
      check_eq("x8.divu.lat", lat, 9);
      check_eq("x8.divu.rd", rd8, 8'd28);
      tick();

      run_op("slt", OpSlt, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0);
      run_op("sltu", OpSltu, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
      run_op("eq", OpEq, 32'h1234, 32'h1234, 1, 32'd1, 1'b0);
      run_op("nor", OpNor, 32'h0F0F_0000, 32'h0000_00FF, 1, 32'hF0F0_FF00, 1'b0);
      run_op("mul", OpMul, 32'd6, 32'd7, 33, 32'd42, 1'b0);
      run_op("mulh", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd0, 1'b0);
      check_eq("mulh.zero", zero, 1);
      run_op("mulhu", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
      run_op("mulhsu", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF, 1'b0);
      run_op("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
      run_op("rem", OpRem, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);
      run_op("divu0", OpDivu, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
      run_op("remu0", OpRemu, 32'd9, 32'd0, 1, 32'd9, 1'b0);
      run_op("divovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
      run_op("removf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);
      run_op("illegal", 5'b01011, 32'd3, 32'd4, 1, 32'd0, 1'b1);
      check_eq("illegal.zero", zero, 1);
      tick();

      // Backpressure: result held while out_ready low
      out_ready = 1'b0;
      check_eq("bp.in_ready_idle", in_ready, 1);
      op = OpAdd; rs1 = 32'd3; rs2 = 32'd4; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_eq("bp.valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp.rd_stable", rd, 32'd7);
         check_eq("bp.in_ready_low", in_ready, 0);
         check_eq("bp.valid_held", out_valid, 1);
      end
      out_ready = 1'b1;
      tick();
      check_eq("bp.release", out_valid, 0);

      // Flush mid-DIV
      op = OpDiv; rs1 = 32'd100; rs2 = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         tick();
         seen |= out_valid;
      end
      flush = 1'b1;
      #1;
      check_eq("flush.in_ready_during", in_ready, 0);
      tick();
      flush = 1'b0;
      #1;
      check_eq("flush.in_ready_next", in_ready, 1);
      repeat (40) begin
         seen |= out_valid;
         tick();
      end
      check_eq("flush.never_valid", seen, 0);
      run_op("post_flush", OpAdd, 32'd1, 32'd1, 1, 32'd2, 1'b0);
      tick();

      // Reset mid-MUL
      op = OpMul; rs1 = 32'd6; rs2 = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      check_eq("rstmid.out_valid", out_valid, 0);
      check_eq("rstmid.rd", rd, 0);
      check_eq("rstmid.illegal", ill, 0);
      check_eq("rstmid.zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         tick();
         seen |= out_valid;
      end
      check_eq("rstmid.never_valid", seen, 0);
      run_op("post_rst", OpXor, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'hF00F_F00F, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
